// File: rtl/axis_mux_pkg.sv
// rtl/axis_mux_pkg.sv - arbiter states and round-robin helper shared by axis_mux
package axis_mux_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   function automatic int rr_next(input int idx, input int num);
      return (idx + 1 >= num) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axis_mux_fifo.sv
// rtl/axis_mux_fifo.sv - synchronous first-word-fall-through FIFO, one per mux source
module axis_mux_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             wr_do;
   logic             rd_do;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign wr_do   = wr_en && !full;
   assign rd_do   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_do) wr_ptr <= wr_ptr + 1'b1;
         if (rd_do) rd_ptr <= rd_ptr + 1'b1;
         // simultaneous write and read leaves the count unchanged
         case ({wr_do, rd_do})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_do) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/axis_mux.sv
// rtl/axis_mux.sv - N-to-1 AXI4-Stream packet mux with per-source FIFOs and round-robin packet arbitration
module axis_mux
   import axis_mux_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int USER_WIDTH  = 1,
   parameter int NUM_SOURCES = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_SOURCES-1:0]            s_tvalid,
   output logic [NUM_SOURCES-1:0]            s_tready,
   input  logic [NUM_SOURCES-1:0]            s_tlast,
   input  logic [DATA_WIDTH*NUM_SOURCES-1:0] s_tdata,
   input  logic [USER_WIDTH*NUM_SOURCES-1:0] s_tuser,
   output logic                              m_tvalid,
   input  logic                              m_tready,
   output logic                              m_tlast,
   output logic [DATA_WIDTH-1:0]             m_tdata,
   output logic [USER_WIDTH-1:0]             m_tuser
);

   localparam int GW = $clog2(NUM_SOURCES);
   localparam int FW = USER_WIDTH + 1 + DATA_WIDTH;

   logic [FW-1:0]          head [NUM_SOURCES];
   logic [FW-1:0]          head_g;
   logic [NUM_SOURCES-1:0] full;
   logic [NUM_SOURCES-1:0] empty;
   logic [NUM_SOURCES-1:0] wr_en;
   logic [NUM_SOURCES-1:0] rd_en;

   state_t         state, state_nx;
   logic [GW-1:0]  grant, grant_nx;
   logic [GW-1:0]  last_grant, last_grant_nx;
   logic [GW-1:0]  idx;
   logic           found;

   assign s_tready = ~full & {NUM_SOURCES{!rst}};

   for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      assign wr_en[gi] = s_tvalid[gi] && s_tready[gi];
      assign rd_en[gi] = (state == ST_ACTIVE) && (grant == GW'(gi)) && m_tready && !empty[gi];

      axis_mux_fifo #(
         .WIDTH (FW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en[gi]),
         .wr_data ({s_tuser[gi*USER_WIDTH +: USER_WIDTH], s_tlast[gi],
                    s_tdata[gi*DATA_WIDTH +: DATA_WIDTH]}),
         .rd_en   (rd_en[gi]),
         .rd_data (head[gi]),
         .full    (full[gi]),
         .empty   (empty[gi])
      );
   end

   // datapath always follows the granted FIFO head so the outputs never carry X from control
   assign head_g   = head[grant];
   assign m_tdata  = head_g[DATA_WIDTH-1:0];
   assign m_tlast  = head_g[DATA_WIDTH];
   assign m_tuser  = head_g[FW-1 -: USER_WIDTH];
   assign m_tvalid = (state == ST_ACTIVE) && !empty[grant];

   always_comb begin
      state_nx      = state;
      grant_nx      = grant;
      last_grant_nx = last_grant;
      idx           = last_grant;
      found         = 1'b0;
      case (state)
         ST_IDLE: begin
            for (int k = 0; k < NUM_SOURCES; k++) begin
               idx = GW'(rr_next(int'(idx), NUM_SOURCES));
               if (!found && !empty[idx]) begin
                  found    = 1'b1;
                  grant_nx = idx;
                  state_nx = ST_ACTIVE;
               end
            end
         end
         ST_ACTIVE: begin
            if (m_tvalid && m_tready && m_tlast) begin
               last_grant_nx = grant;
               state_nx      = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= GW'(NUM_SOURCES - 1);
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         last_grant <= last_grant_nx;
      end
   end

endmodule

// File: tb/tb_axis_mux.sv
// tb/tb_axis_mux.sv - directed checks of axis_mux latency, ordering, backpressure, reset and fairness
module tb_axis_mux;

   localparam int NS = 4;
   localparam int DW = 32;
   localparam int UW = 1;
   localparam int FD = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NS-1:0]    s_tvalid;
   logic [NS-1:0]    s_tready;
   logic [NS-1:0]    s_tlast;
   logic [DW*NS-1:0] s_tdata;
   logic [UW*NS-1:0] s_tuser;
   logic             m_tvalid;
   logic             m_tready;
   logic             m_tlast;
   logic [DW-1:0]    m_tdata;
   logic [UW-1:0]    m_tuser;

   always #5 clk = ~clk;

   axis_mux #(
      .FIFO_DEPTH  (FD),
      .DATA_WIDTH  (DW),
      .USER_WIDTH  (UW),
      .NUM_SOURCES (NS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tlast  (s_tlast),
      .s_tdata  (s_tdata),
      .s_tuser  (s_tuser),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .m_tdata  (m_tdata),
      .m_tuser  (m_tuser)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   typedef struct {
      int            src;
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic [DW-1:0] exp_data;
      logic [UW-1:0] exp_user;
   } vec_t;

   beat_t q[$];
   vec_t  vecs[4];
   int    n_checks = 0;
   int    n_pass   = 0;

   // inputs change 1ns after posedge, so the negedge sees exactly what the next edge will accept
   always @(negedge clk) begin
      if (!rst && m_tvalid && m_tready) q.push_back('{m_tdata, m_tuser, m_tlast});
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_tvalid = '0;
      s_tlast  = '0;
   endtask

   task automatic drive(input int src, input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
      s_tvalid[src]         = 1'b1;
      s_tdata[src*DW +: DW] = d;
      s_tuser[src*UW +: UW] = u;
      s_tlast[src]          = l;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      rst = 1'b0;
      tick();
      q.delete();
   endtask

   logic [5:0] a_v, a_l, b_v, b_l;
   logic [DW-1:0] exp_d [6];
   logic          exp_l [6];
   int ai, bi, k, cnt[NS], cmin, cmax, rr_viol;
   logic rdy;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{2, 32'h00CACA01, 1'b0, 32'h00CACA01, 1'b0};
      vecs[1] = '{0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
      vecs[2] = '{3, 32'h12345678, 1'b1, 32'h12345678, 1'b1};
      vecs[3] = '{1, 32'h00000000, 1'b0, 32'h00000000, 1'b0};

      rst = 1'b1; m_tready = 1'b0; s_tdata = '0; s_tuser = '0;
      idle_inputs();
      repeat (2) tick();
      chk("reset_s_tready", s_tready, 0);
      chk("reset_m_tvalid", m_tvalid, 0);
      rst = 1'b0;
      tick();
      chk("post_reset_s_tready", s_tready, 4'hF);
      chk("post_reset_m_tvalid", m_tvalid, 0);

      // single-beat vectors: valid exactly two edges after acceptance, one beat out
      m_tready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         q.delete();
         drive(vecs[v].src, vecs[v].data, vecs[v].user, 1'b1);
         tick();
         idle_inputs();
         chk($sformatf("vec%0d_lat1_valid", v), m_tvalid, 0);
         tick();
         chk($sformatf("vec%0d_valid", v), m_tvalid, 1);
         chk($sformatf("vec%0d_data", v), m_tdata, vecs[v].exp_data);
         chk($sformatf("vec%0d_user", v), m_tuser, vecs[v].exp_user);
         chk($sformatf("vec%0d_last", v), m_tlast, 1);
         tick();
         chk($sformatf("vec%0d_after_valid", v), m_tvalid, 0);
         repeat (3) tick();
         chk($sformatf("vec%0d_count", v), q.size(), 1);
      end

      // all four sources at once after reset: order 0..3 with one idle cycle between
      do_reset();
      for (int i = 0; i < NS; i++) drive(i, (32'(i) << 24) | 32'h00CACA01, 1'b0, 1'b1);
      tick();
      idle_inputs();
      chk("all4_lat1_valid", m_tvalid, 0);
      for (int t = 0; t < 8; t++) begin
         tick();
         chk($sformatf("all4_valid_t%0d", t), m_tvalid, (t % 2 == 0));
         if (t % 2 == 0) chk($sformatf("all4_data_t%0d", t), m_tdata, (32'(t / 2) << 24) | 32'h00CACA01);
      end
      chk("all4_count", q.size(), 4);

      // concurrent 3-beat packets, source 0 stalls mid-packet
      do_reset();
      a_v = 6'b101001; a_l = 6'b100000;
      b_v = 6'b000111; b_l = 6'b000100;
      ai = 0; bi = 0;
      for (int t = 0; t < 6; t++) begin
         idle_inputs();
         if (a_v[t]) begin drive(0, 32'hA000 + 32'(ai), 1'b0, a_l[t]); ai++; end
         if (b_v[t]) begin drive(1, 32'hB000 + 32'(bi), 1'b0, b_l[t]); bi++; end
         tick();
         if (t == 2) chk("stall_valid_low", m_tvalid, 0);
         if (t == 3) chk("stall_resume_data", m_tdata, 32'hA001);
      end
      idle_inputs();
      repeat (12) tick();
      exp_d = '{32'hA000, 32'hA001, 32'hA002, 32'hB000, 32'hB001, 32'hB002};
      exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      chk("noint_count", q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < q.size()) begin
            chk($sformatf("noint_data%0d", i), q[i].data, exp_d[i]);
            chk($sformatf("noint_last%0d", i), q[i].last, exp_l[i]);
         end
      end

      // backpressure: source 3 fills its FIFO, then drains under random ready
      do_reset();
      m_tready = 1'b0;
      k = 0;
      for (int c = 0; c < 20; c++) begin
         idle_inputs();
         if (k < 12) drive(3, 32'h3000 + 32'(k), 1'b0, k == 11);
         rdy = s_tready[3];
         tick();
         if (rdy && k < 12) k++;
      end
      chk("bp_accepted", k, 8);
      chk("bp_ready_low", s_tready[3], 0);
      chk("bp_valid_held", m_tvalid, 1);
      chk("bp_nothing_out", q.size(), 0);
      for (int c = 0; c < 400 && q.size() < 12; c++) begin
         m_tready = 1'($urandom_range(0, 1));
         idle_inputs();
         if (k < 12) drive(3, 32'h3000 + 32'(k), 1'b0, k == 11);
         rdy = s_tready[3];
         tick();
         if (rdy && k < 12) k++;
      end
      idle_inputs();
      m_tready = 1'b1;
      repeat (4) tick();
      chk("bp_total_in", k, 12);
      chk("bp_total_out", q.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < q.size()) begin
            chk($sformatf("bp_data%0d", i), q[i].data, 32'h3000 + 32'(i));
            chk($sformatf("bp_last%0d", i), q[i].last, i == 11);
         end
      end

      // reset in the middle of a packet
      do_reset();
      for (int t = 0; t < 4; t++) begin
         idle_inputs();
         drive(1, 32'h5100 + 32'(t), 1'b0, 1'b0);
         if (t == 0) drive(2, 32'h5200, 1'b0, 1'b1);
         tick();
      end
      chk("mid_partial_out", q.size() > 0, 1);
      drive(1, 32'h51FF, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      chk("mid_rst_s_tready", s_tready, 0);
      chk("mid_rst_m_tvalid", m_tvalid, 0);
      rst = 1'b0;
      idle_inputs();
      tick();
      q.delete();
      chk("mid_post_s_tready", s_tready, 4'hF);
      chk("mid_post_m_tvalid", m_tvalid, 0);
      repeat (3) tick();
      chk("mid_flushed", q.size(), 0);
      drive(0, 32'h6000, 1'b0, 1'b0);
      drive(1, 32'h6100, 1'b0, 1'b0);
      tick();
      drive(0, 32'h6001, 1'b0, 1'b1);
      drive(1, 32'h6101, 1'b0, 1'b1);
      tick();
      idle_inputs();
      repeat (10) tick();
      chk("mid_fresh_count", q.size(), 4);
      exp_d[0] = 32'h6000; exp_d[1] = 32'h6001; exp_d[2] = 32'h6100; exp_d[3] = 32'h6101;
      for (int i = 0; i < 4; i++) begin
         if (i < q.size()) chk($sformatf("mid_fresh_data%0d", i), q[i].data, exp_d[i]);
      end

      // continuous traffic on all sources: strict rotation and balanced grants
      do_reset();
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < NS; i++) drive(i, {8'(i), 24'(c)}, 1'b0, 1'b1);
         tick();
      end
      idle_inputs();
      for (int i = 0; i < NS; i++) cnt[i] = 0;
      rr_viol = 0;
      for (int j = 0; j < q.size(); j++) begin
         cnt[q[j].data[31:24]]++;
         if (j > 0 && int'(q[j].data[31:24]) != (int'(q[j-1].data[31:24]) + 1) % NS) rr_viol++;
      end
      cmin = cnt[0]; cmax = cnt[0];
      for (int i = 1; i < NS; i++) begin
         if (cnt[i] < cmin) cmin = cnt[i];
         if (cnt[i] > cmax) cmax = cnt[i];
      end
      chk("fair_first_src0", (q.size() > 0) && (q[0].data[31:24] == 8'd0), 1);
      chk("fair_rotation", rr_viol, 0);
      chk("fair_spread", (cmax - cmin) <= 1, 1);
      chk("fair_throughput", (q.size() >= 240) && (q.size() <= 250), 1);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_mux.md
Name: axis_mux

Overview:
- Single-clock N-to-1 AXI4-Stream packet multiplexer.
- Each source port feeds its own small FIFO; a round-robin arbiter forwards whole packets (no interleaving) to one master port.
- Sits between several packet generators (e.g. per-link test streamers) and a single packet consumer/checker.

Parameters:
- FIFO_DEPTH, 8, entries per source FIFO; power of two, ≥2.
- DATA_WIDTH, 32, tdata width.
- USER_WIDTH, 1, tuser width.
- NUM_SOURCES, 4, number of slave ports; ≥2.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_tvalid  in  NUM_SOURCES  per-source valid; bit i = source i.
- s_tready  out  NUM_SOURCES  per-source ready.
- s_tlast  in  NUM_SOURCES  per-source end of packet.
- s_tdata  in  DATA_WIDTH*NUM_SOURCES  flattened; source i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- s_tuser  in  USER_WIDTH*NUM_SOURCES  flattened, same packing as s_tdata.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  output end of packet.
- m_tdata  out  DATA_WIDTH  output data.
- m_tuser  out  USER_WIDTH  output user.

Behaviour:
- Source FIFOs:
  - One synchronous first-word-fall-through FIFO per source, storing {tuser, tlast, tdata}, FIFO_DEPTH entries.
  - s_tready[i] = !full[i] && !rst.
  - A write occurs when s_tvalid[i] && s_tready[i].
  - Overflow is impossible; no data is ever dropped.
- Arbiter FSM:
  - State ST_IDLE: each cycle, search sources starting at (lastGrant+1) mod NUM_SOURCES and pick the first with a non-empty FIFO. If one is found, register grant <= that index and go to ST_ACTIVE. Otherwise stay in ST_IDLE.
  - State ST_ACTIVE: m_tvalid = !empty[grant]; m_tdata/m_tuser/m_tlast come from the head of FIFO[grant] (combinational). A read occurs on m_tvalid && m_tready.
  - If the read beat has tlast=1: lastGrant <= grant and go to ST_IDLE.
  - Grant is held for the whole packet, including cycles where FIFO[grant] runs empty mid-packet (m_tvalid=0, wait).
  - In ST_IDLE, m_tvalid=0.
- Latency:
  - A beat accepted on source i at cycle N appears in the FIFO head at N+1.
  - If the mux was idle, grant registers at N+1 and m_tvalid asserts at N+2 (minimum latency 2).
  - Back-to-back packets from different sources have one idle cycle between a tlast handshake and the next packet's first beat.
- Fairness: strict round-robin per packet. Simultaneous single-beat packets on all sources (after reset) emerge in order 0,1,2,…,NUM_SOURCES-1.
- Simultaneous write and read on the same FIFO: both occur, count unchanged. A full FIFO being read still deasserts s_tready that cycle; ready is based on registered full.
- Count/pointer arithmetic: pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits.
- Packets longer than FIFO_DEPTH are supported; they stream through under the grant.
- Reset (synchronous, any time including mid-packet):
  - All FIFOs emptied; state=ST_IDLE; lastGrant=NUM_SOURCES-1, so source 0 has first priority; grant=0.
  - Outputs during and after reset: m_tvalid=0, s_tready=0 while rst=1 (all ones from the first cycle after reset).
  - Partial packets in flight are discarded.
- m_tdata/m_tuser/m_tlast are don't-care when m_tvalid=0, but are driven from the FIFO head (no X from control).

Decomposition:
- Shared package (axis_mux_pkg): state localparams ST_IDLE=0, ST_ACTIVE=1; a helper function returning the round-robin next index.
- Widths are derived with $clog2 locally.
- One natural sub-module, axis_mux_fifo: parameterised sync FWFT FIFO (WIDTH, DEPTH) with wr_en/rd_en/full/empty, instantiated NUM_SOURCES times in a generate loop.

Test Plan:
- Single beat 0x00CACA01, tlast=1 on source 2, m_tready=1 → m_tvalid at +2 cycles, m_tdata=0x00CACA01, m_tlast=1, exactly one beat out.
- All 4 sources present one 1-beat packet in the same cycle (tdata=0x00CACA01, 0x01CACA01, 0x02CACA01, 0x03CACA01) → output order source 0,1,2,3, one idle cycle between packets.
- Sources 0 and 1 each send 3-beat packets concurrently, with source 0 stalling mid-packet → output beats never interleave; source 1's packet follows source 0's tlast.
- m_tready held 0, source 3 streams 12 beats → s_tready[3] drops after 8 accepted beats. Release m_tready with 50% random ready → all 12 beats out in order, none lost or duplicated.
- Assert rst for 1 cycle while a packet is half-transferred → m_tvalid=0 next cycle, FIFOs empty, s_tready=0 during rst. A fresh packet afterwards emerges intact, with source 0 winning any tie.
- Continuous 1-beat traffic on all sources for 500 cycles with m_tready=1 → per-source grant counts differ by ≤1.
